// File: rtl/sockit_spi_sdiv.sv
// SPI master serializer/deserializer with an internal SCLK divider.
// Supports 3-wire, single, dual and quad IO, programmable length and bit order.
module sockit_spi_sdiv #(
    parameter int SSW = 8,
    parameter int SDW = 8,
    parameter int SDL = 3,
    parameter int CDW = 8,
    parameter int QCO = SDL + 7,
    parameter int QCI = 4,
    parameter int QDW = 4 * SDW
) (
    input  logic           spi_sclk,
    input  logic           rst,
    input  logic [CDW-1:0] cfg_div,
    input  logic           cfg_pol,
    input  logic           cfg_pha,
    input  logic           cfg_dir,
    input  logic [SSW-1:0] cfg_sss,
    input  logic           quo_vld,
    input  logic [QCO-1:0] quo_ctl,
    input  logic [QDW-1:0] quo_dat,
    output logic           quo_rdy,
    output logic           qui_vld,
    output logic [QCI-1:0] qui_ctl,
    output logic [QDW-1:0] qui_dat,
    input  logic           qui_rdy,
    output logic           sclk_o,
    input  logic [3:0]     sio_i,
    output logic [3:0]     sio_o,
    output logic [3:0]     sio_e,
    output logic [SSW-1:0] ss_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    // Both queues use valid/ready: a word moves on a rising edge where valid and ready are both high;
    // valid, once raised, holds its payload stable until that edge.

    state_t           state_q, state_d;
    logic [CDW-1:0]   div_q, div_d;
    logic             half_q, half_d;
    logic [SDL-1:0]   bit_q, bit_d;
    logic             tgl_q, tgl_d;
    logic             cke_q, cke_d;
    logic             die_q, die_d;
    logic [1:0]       iom_q, iom_d;
    logic             lst_q, lst_d;
    logic [SDL-1:0]   len_q, len_d;
    logic [QDW-1:0]   sh_q, sh_d;
    logic [3:0]       smp_q, smp_d;
    logic             qvld_q, qvld_d;
    logic [SSW-1:0]   ss_q, ss_d;
    logic [3:0]       sioe_q, sioe_d;

    logic       hp_end, lead_end, trail_end, last_bit, do_smp, do_shift;
    logic [3:0] sin, ins, lane_use;

    function automatic logic [3:0] lane_mask(input logic [1:0] iom);
        case (iom)
            2'd3:    lane_mask = 4'b1111;
            2'd2:    lane_mask = 4'b0011;
            default: lane_mask = 4'b0001;
        endcase
    endfunction

    always_ff @(posedge spi_sclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            tgl_q   <= 1'b0;
            cke_q   <= 1'b0;
            die_q   <= 1'b0;
            iom_q   <= '0;
            lst_q   <= 1'b0;
            len_q   <= '0;
            sh_q    <= '0;
            smp_q   <= '0;
            qvld_q  <= 1'b0;
            ss_q    <= '0;
            sioe_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            tgl_q   <= tgl_d;
            cke_q   <= cke_d;
            die_q   <= die_d;
            iom_q   <= iom_d;
            lst_q   <= lst_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            smp_q   <= smp_d;
            qvld_q  <= qvld_d;
            ss_q    <= ss_d;
            sioe_q  <= sioe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        bit_d   = bit_q;
        tgl_d   = tgl_q;
        cke_d   = cke_q;
        die_d   = die_q;
        iom_d   = iom_q;
        lst_d   = lst_q;
        len_d   = len_q;
        sh_d    = sh_q;
        smp_d   = smp_q;
        qvld_d  = qvld_q;
        ss_d    = ss_q;
        sioe_d  = sioe_q;

        lane_use  = lane_mask(iom_q);
        sin       = {sio_i[3:1], (iom_q == 2'd0) ? sio_i[0] : sio_i[1]};
        if (!die_q) sin = '0;
        hp_end    = (state_q == SHIFT) && (div_q == '0);
        lead_end  = hp_end && !half_q;
        trail_end = hp_end && half_q;
        last_bit  = (bit_q == len_q);
        do_smp    = cfg_pha ? trail_end : lead_end;
        // With pha=1 the last sample has no following leading edge, so it is shifted in directly.
        do_shift  = cfg_pha ? ((lead_end && (bit_q != '0)) || (trail_end && last_bit)) : trail_end;
        ins       = (cfg_pha && trail_end) ? sin : smp_q;

        case (state_q)
            IDLE: begin
                tgl_d = 1'b0;
                if (quo_vld && quo_rdy) begin
                    cke_d   = quo_ctl[0];
                    die_d   = quo_ctl[3];
                    iom_d   = quo_ctl[5:4];
                    lst_d   = quo_ctl[6];
                    len_d   = quo_ctl[7 +: SDL];
                    sh_d    = quo_dat;
                    ss_d    = {SSW{quo_ctl[1]}} & cfg_sss;
                    sioe_d  = quo_ctl[2] ? lane_mask(quo_ctl[5:4]) : 4'b0000;
                    div_d   = cfg_div;
                    half_d  = 1'b0;
                    bit_d   = '0;
                    smp_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (hp_end) begin
                    div_d  = cfg_div;
                    half_d = !half_q;
                    if (cke_q) tgl_d = !tgl_q;
                end else begin
                    div_d = div_q - 1'b1;
                end
                if (do_smp) smp_d = sin;
                if (do_shift) begin
                    for (int k = 0; k < 4; k++) begin
                        if (lane_use[k]) begin
                            sh_d[k*SDW +: SDW] = cfg_dir ? {sh_q[k*SDW +: SDW-1], ins[k]}
                                                         : {ins[k], sh_q[k*SDW+1 +: SDW-1]};
                        end
                    end
                end
                if (trail_end) begin
                    if (last_bit) begin
                        state_d = DONE;
                        tgl_d   = 1'b0;
                        qvld_d  = die_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            DONE: begin
                tgl_d = 1'b0;
                if (!die_q) begin
                    state_d = IDLE;
                end else if (qvld_q && qui_rdy) begin
                    qvld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sio_o = '0;
        for (int k = 0; k < 4; k++) begin
            sio_o[k] = cfg_dir ? sh_q[k*SDW + SDW - 1] : sh_q[k*SDW];
        end
    end

    assign quo_rdy = (state_q == IDLE) && !qvld_q;
    assign qui_vld = qvld_q;
    assign qui_ctl = QCI'({lst_q, iom_q});
    assign qui_dat = sh_q;
    assign sclk_o  = cfg_pol ^ tgl_q;
    assign sio_e   = sioe_q;
    assign ss_o    = ss_q;

endmodule
